// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM encoding and idle strobe levels for the SRAM arbiter
package sram_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_e;
    localparam logic       STROBE_OFF = 1'b1;
    localparam logic [3:0] BE_NONE    = 4'hF;
    localparam int         TIMER_W    = 8;
endpackage

// File: rtl/sram_timer.sv
// sram_timer: loadable down-counter that parks at zero and flags the last wait cycle
module sram_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    // load a fresh wait length, otherwise count down until zero
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: serialises IF and MEM requests onto one SRAM with fixed strobe timing
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int READ_WAIT = 1,
    parameter int WR_PULSE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              stall_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [31:0]       ram_dq_o,
    output logic              ram_dq_oe,
    input  logic [31:0]       ram_dq_i
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_n_q;
    logic [31:0]         dq_q, if_data_q, mem_rdata_q;
    logic                ce_n_q, oe_n_q, we_n_q, dq_oe_q;
    logic                mem_ack_q, if_ack_q, mem_done_q, if_done_q, sel_mem_q;
    logic                mem_go, if_go, rd_done, wr_done, t_load, t_zero;
    logic [TIMER_W-1:0]  t_val;
    logic                unused_addr;

    assign mem_go    = mem_ce & ~mem_done_q & ~mem_ack_q;
    assign if_go     = if_ce & ~if_done_q & ~if_ack_q;
    assign stall_req = mem_go | if_go;
    assign rd_done   = (state_q == ST_RD) & t_zero;
    assign wr_done   = (state_q == ST_WR_HOLD);
    assign t_load    = (state_q == ST_WR_SETUP) | (state_q == ST_IDLE & state_d == ST_RD);
    assign t_val     = (state_q == ST_WR_SETUP) ? TIMER_W'(WR_PULSE - 1) : TIMER_W'(READ_WAIT - 1);

    assign ram_addr  = addr_q;
    assign ram_be_n  = be_n_q;
    assign ram_ce_n  = ce_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;
    assign ram_dq_o  = dq_q;
    assign ram_dq_oe = dq_oe_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

    assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    sram_timer #(.W(TIMER_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (t_load),
        .val_i  (t_val),
        .zero_o (t_zero)
    );

    // next-state: MEM wins arbitration in IDLE, timed states wait on the shared timer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = mem_go ? (mem_we ? ST_WR_SETUP : ST_RD) : (if_go ? ST_RD : ST_IDLE);
            ST_RD:       state_d = t_zero ? ST_IDLE : ST_RD;
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: state_d = t_zero ? ST_WR_HOLD : ST_WR_PULSE;
            ST_WR_HOLD:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // state, registered strobes derived from the next state, latched request, acks and read data
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= ST_IDLE;
            ce_n_q      <= STROBE_OFF;
            oe_n_q      <= STROBE_OFF;
            we_n_q      <= STROBE_OFF;
            dq_oe_q     <= 1'b0;
            addr_q      <= '0;
            be_n_q      <= BE_NONE;
            dq_q        <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            mem_ack_q   <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_done_q  <= 1'b0;
            if_done_q   <= 1'b0;
            sel_mem_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ce_n_q     <= (state_d == ST_IDLE) ? STROBE_OFF : ~STROBE_OFF;
            oe_n_q     <= (state_d == ST_RD) ? ~STROBE_OFF : STROBE_OFF;
            we_n_q     <= (state_d == ST_WR_PULSE) ? ~STROBE_OFF : STROBE_OFF;
            dq_oe_q    <= state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
            mem_ack_q  <= (rd_done & sel_mem_q) | wr_done;
            if_ack_q   <= rd_done & ~sel_mem_q;
            mem_done_q <= stall_req & (mem_done_q | mem_ack_q);
            if_done_q  <= stall_req & (if_done_q | if_ack_q);
            if (state_q == ST_IDLE && mem_go) begin
                addr_q    <= mem_addr[ADDR_W+1:2];
                be_n_q    <= ~mem_sel;
                dq_q      <= mem_wdata;
                sel_mem_q <= 1'b1;
            end else if (state_q == ST_IDLE && if_go) begin
                addr_q    <= if_addr[ADDR_W+1:2];
                be_n_q    <= 4'h0;
                sel_mem_q <= 1'b0;
            end
            if (rd_done & sel_mem_q)
                mem_rdata_q <= ram_dq_i;
            if (rd_done & ~sel_mem_q)
                if_data_q <= ram_dq_i;
        end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors and corner sequences against a behavioural SRAM
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce, mem_ce, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_data, mem_rdata, ram_dq_o, ram_dq_i;
    logic        stall_req, ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;

    int checks = 0;
    int failures = 0;
    int we_low = 0;
    int overlap = 0;
    logic [19:0] acc_log[$];
    logic [31:0] sram [0:255];
    logic        ce_prev = 1'b1;

    typedef struct {
        logic        ice;
        logic [31:0] iaddr;
        logic        mce;
        logic        mwe;
        logic [31:0] maddr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          e_stall;
        logic [19:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_if;
        logic [31:0] e_mem;
        int          e_we;
    } vec_t;
    vec_t vecs[8];

    sram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_ce     (if_ce),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_sel   (mem_sel),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_req (stall_req),
        .ram_addr  (ram_addr),
        .ram_be_n  (ram_be_n),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram_dq_o  (ram_dq_o),
        .ram_dq_oe (ram_dq_oe),
        .ram_dq_i  (ram_dq_i)
    );

    always #5 clk = ~clk;

    assign ram_dq_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[7:0]] : 32'h0;

    // SRAM model and bus monitor, sampled on the falling edge
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 32'h0;
        sram[2]    = 32'hAAAA_5555;
        sram[4]    = 32'h3C01_8000;
        sram[8]    = 32'h1111_2222;
        sram[8'h40] = 32'h0123_4567;
        forever begin
            @(negedge clk);
            if (!ram_ce_n && !ram_we_n)
                for (int b = 0; b < 4; b++)
                    if (!ram_be_n[b]) sram[ram_addr[7:0]][8*b +: 8] = ram_dq_o[8*b +: 8];
            if (!ram_we_n) we_low++;
            if (ram_dq_oe && !ram_oe_n) overlap++;
            if (ce_prev && !ram_ce_n) acc_log.push_back(ram_addr);
            ce_prev = ram_ce_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_ce = 0; mem_ce = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_sel = 0; mem_wdata = 0;
    endtask

    task automatic wait_stall_low(output int n);
        n = 0;
        while (stall_req && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic run_vec(input int i);
        int n, we0;
        we0 = we_low;
        @(negedge clk);
        if_ce = vecs[i].ice; if_addr = vecs[i].iaddr;
        mem_ce = vecs[i].mce; mem_we = vecs[i].mwe; mem_addr = vecs[i].maddr;
        mem_sel = vecs[i].sel; mem_wdata = vecs[i].wdata;
        #1;
        wait_stall_low(n);
        chk($sformatf("v%0d_stall_cycles", i), 32'(n), 32'(vecs[i].e_stall));
        chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_be_n", i), 32'(ram_be_n), 32'(vecs[i].e_be));
        chk($sformatf("v%0d_if_data", i), if_data, vecs[i].e_if);
        chk($sformatf("v%0d_mem_rdata", i), mem_rdata, vecs[i].e_mem);
        chk($sformatf("v%0d_we_low_cycles", i), 32'(we_low - we0), 32'(vecs[i].e_we));
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        int n, base;
        logic [8:0] pat;
        vecs[0] = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   4'h0,    32'h0,         2, 20'h4,  4'h0,    32'h3C01_8000, 32'h0,         0};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 4'b0011, 32'hDEAD_BEEF, 5, 20'h40, 4'b1100, 32'h3C01_8000, 32'h0,         2};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 4'hF,    32'h0,         2, 20'h40, 4'h0,    32'h3C01_8000, 32'h0123_BEEF, 0};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 4'h0,    32'hFFFF_FFFF, 5, 20'h40, 4'hF,    32'h3C01_8000, 32'h0123_BEEF, 2};
        vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 4'b0101, 32'h0,         2, 20'h40, 4'b1010, 32'h3C01_8000, 32'h0123_BEEF, 0};
        vecs[5] = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0,   4'h0,    32'h0,         2, 20'h2,  4'h0,    32'hAAAA_5555, 32'h0123_BEEF, 0};
        vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   4'hF,    32'hCAFE_F00D, 5, 20'h3,  4'h0,    32'hAAAA_5555, 32'h0123_BEEF, 2};
        vecs[7] = '{1'b1, 32'hC,   1'b0, 1'b0, 32'h0,   4'h0,    32'h0,         2, 20'h3,  4'h0,    32'hCAFE_F00D, 32'h0123_BEEF, 0};

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ce_n", 32'(ram_ce_n), 32'h1);
        chk("rst_oe_n", 32'(ram_oe_n), 32'h1);
        chk("rst_we_n", 32'(ram_we_n), 32'h1);
        chk("rst_dq_oe", 32'(ram_dq_oe), 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_be_n", 32'(ram_be_n), 32'hF);
        chk("rst_dq_o", ram_dq_o, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_stall", 32'(stall_req), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i);

        // simultaneous MEM read and IF fetch: MEM first, each word once
        base = acc_log.size();
        @(negedge clk);
        if_ce = 1; if_addr = 32'h8;
        mem_ce = 1; mem_we = 0; mem_addr = 32'h20; mem_sel = 4'hF;
        #1;
        wait_stall_low(n);
        chk("sim_stall_cycles", 32'(n), 32'h4);
        chk("sim_mem_rdata", mem_rdata, 32'h1111_2222);
        chk("sim_if_data", if_data, 32'hAAAA_5555);
        chk("sim_access_count", 32'(acc_log.size() - base), 32'h2);
        if (acc_log.size() - base == 2) begin
            chk("sim_first_addr", 32'(acc_log[base]), 32'h8);
            chk("sim_second_addr", 32'(acc_log[base+1]), 32'h2);
        end
        idle_inputs();
        @(negedge clk);

        // fetch dropped while in flight: completes and captures, no stall
        base = acc_log.size();
        @(negedge clk);
        if_ce = 1; if_addr = 32'h10;
        @(negedge clk);
        if_ce = 0;
        #1;
        chk("drop_stall", 32'(stall_req), 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("drop_if_data", if_data, 32'h3C01_8000);
        chk("drop_access_count", 32'(acc_log.size() - base), 32'h1);
        @(negedge clk);

        // held fetch: a new access each time stall has been low for one cycle
        base = acc_log.size();
        @(negedge clk);
        if_ce = 1; if_addr = 32'h8;
        #1;
        pat[8] = stall_req;
        for (int k = 7; k >= 0; k--) begin
            @(negedge clk); #1;
            pat[k] = stall_req;
        end
        if_ce = 0;
        chk("held_stall_pattern", 32'(pat), 32'(9'b110110110));
        chk("held_access_count", 32'(acc_log.size() - base), 32'h3);
        chk("held_if_data", if_data, 32'hAAAA_5555);
        repeat (2) @(negedge clk);

        chk("no_bus_overlap", 32'(overlap), 32'h0);

        // asynchronous reset in the middle of the write pulse
        @(negedge clk);
        mem_ce = 1; mem_we = 1; mem_addr = 32'h100; mem_sel = 4'h0; mem_wdata = 32'h5A5A_5A5A;
        n = 0;
        while (ram_we_n && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rstmid_we_seen", 32'(ram_we_n), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_we_n", 32'(ram_we_n), 32'h1);
        chk("rstmid_dq_oe", 32'(ram_dq_oe), 32'h0);
        chk("rstmid_ce_n", 32'(ram_ce_n), 32'h1);
        chk("rstmid_mem_rdata", mem_rdata, 32'h0);
        chk("rstmid_if_data", if_data, 32'h0);
        idle_inputs();
        #1;
        chk("rstmid_stall", 32'(stall_req), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        base = acc_log.size();
        repeat (5) @(negedge clk);
        #1;
        chk("rstmid_no_access", 32'(acc_log.size() - base), 32'h0);
        chk("rstmid_ce_idle", 32'(ram_ce_n), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
